// File: rtl/vec_packer32_pkg.sv
// vec_pack_pkg: shared sizes, types and helpers for vec_packer32.
//   WORD_W    - bits per input word
//   NUM_WORDS - words per packed vector
//   VEC_W     - packed vector width
//   CNT_W     - width of the real-word count (1..NUM_WORDS)
//   IDX_W     - width of the fill-buffer write pointer
package vec_pack_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 32;
    localparam int VEC_W     = WORD_W * NUM_WORDS;
    localparam int CNT_W     = $clog2(NUM_WORDS) + 1;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [VEC_W-1:0]  vec_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // FILLING: fill buffer accepts words. HOLD: a completed frame waits
    // in the fill buffer for the output register to drain.
    typedef enum logic {
        FILLING = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // LSB position of slot k; slot 0 occupies the most significant word.
    function automatic int slot_lsb(input int k);
        return VEC_W - (k + 1) * WORD_W;
    endfunction

endpackage

// File: rtl/vec_packer32_if.sv
// vec_packer32_if: word input stream and packed vector output stream.
//   s_valid/s_ready/s_data/s_last - word input handshake
//   m_valid/m_ready/m_data/m_count - packed vector output handshake
// Modport slave is the packer's view, master the producer/consumer view.
interface vec_packer32_if;
    import vec_pack_pkg::*;

    logic  s_valid;
    logic  s_ready;
    word_t s_data;
    logic  s_last;
    logic  m_valid;
    logic  m_ready;
    vec_t  m_data;
    cnt_t  m_count;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_count
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_count
    );

endinterface

// File: rtl/vec_packer32.sv
// vec_packer32: collects WORD_W-bit words into a NUM_WORDS-word packed
// vector (word 0 in the MSBs), padding short frames with PAD_VALUE.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - slave side of vec_packer32_if (word in, vector out)
// A fill buffer feeds an output register so one word per cycle is
// sustained; a completed frame waits in the fill buffer (HOLD) only when
// the output register is occupied and not being drained.
module vec_packer32
    import vec_pack_pkg::*;
#(
    parameter word_t PAD_VALUE = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    vec_packer32_if.slave  bus
);

    state_t            state_q, state_d;
    word_t             fill_buf [NUM_WORDS];
    logic [IDX_W-1:0]  wr_idx;
    cnt_t              hold_cnt;

    logic              m_valid_q;
    vec_t              m_data_q;
    cnt_t              m_count_q;

    logic              accept;
    logic              complete;
    logic              out_free;
    logic              load_out;
    logic              park;
    cnt_t              load_cnt;
    vec_t              merged_vec;

    assign accept   = bus.s_valid & bus.s_ready;
    assign complete = accept & ((wr_idx == IDX_W'(NUM_WORDS - 1)) | bus.s_last);
    assign out_free = ~m_valid_q | bus.m_ready;

    // Fill buffer with the word being accepted this cycle merged in, so a
    // completing word lands in the output register on the same edge.
    always_comb begin
        merged_vec = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            merged_vec[slot_lsb(k) +: WORD_W] =
                (accept && (wr_idx == IDX_W'(k))) ? bus.s_data : fill_buf[k];
        end
    end

    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        park     = 1'b0;
        load_cnt = hold_cnt;
        case (state_q)
            FILLING: begin
                if (complete) begin
                    if (out_free) begin
                        load_out = 1'b1;
                        load_cnt = cnt_t'(wr_idx) + cnt_t'(1);
                    end else begin
                        park    = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // m_valid is necessarily high here, so m_ready frees the register.
                if (bus.m_ready) begin
                    load_out = 1'b1;
                    state_d  = FILLING;
                end
            end
            default: state_d = FILLING;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FILLING;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || load_out) begin
            for (int k = 0; k < NUM_WORDS; k++) fill_buf[k] <= PAD_VALUE;
            wr_idx <= '0;
        end else if (accept) begin
            fill_buf[wr_idx] <= bus.s_data;
            wr_idx           <= wr_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)    hold_cnt <= '0;
        else if (park) hold_cnt <= cnt_t'(wr_idx) + cnt_t'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_count_q <= '0;
            m_data_q  <= {NUM_WORDS{PAD_VALUE}};
        end else if (load_out) begin
            m_valid_q <= 1'b1;
            m_count_q <= load_cnt;
            m_data_q  <= merged_vec;
        end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign bus.s_ready = rst_n & (state_q != HOLD);
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_count = m_count_q;

endmodule

// File: tb/tb_vec_packer32.sv
// tb_vec_packer32: directed bench for vec_packer32.
module tb_vec_packer32;
    import vec_pack_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    word_t ew [NUM_WORDS];
    vec_t  vec_a;
    vec_t  vec_b;

    vec_packer32_if bus ();

    vec_packer32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input vec_t got, input vec_t exp);
        int bad;
        bad = -1;
        for (int k = NUM_WORDS - 1; k >= 0; k--)
            if (got[(NUM_WORDS-1-k)*WORD_W +: WORD_W] !== exp[(NUM_WORDS-1-k)*WORD_W +: WORD_W]) bad = k;
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s slot %0d observed=%0h expected=%0h", tag, bad,
                   got[(NUM_WORDS-1-bad)*WORD_W +: WORD_W], exp[(NUM_WORDS-1-bad)*WORD_W +: WORD_W]);
        end
    endtask

    task automatic clr_ew();
        for (int i = 0; i < NUM_WORDS; i++) ew[i] = '0;
    endtask

    // Word i sits at bit position (NUM_WORDS-1-i)*WORD_W, word 0 highest.
    function automatic vec_t build();
        vec_t v;
        for (int i = 0; i < NUM_WORDS; i++) v[(NUM_WORDS-1-i)*WORD_W +: WORD_W] = ew[i];
        return v;
    endfunction

    task automatic send_word(input word_t d, input logic last);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        step();
        bus.s_valid = 1'b0;
        bus.s_data  = 32'hBADC0FFE;
        bus.s_last  = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_count", 64'(bus.m_count), 64'd0);
        chk_vec("rst_m_data", bus.m_data, '0);
        rst_n = 1'b1;
        step();
        chk("post_rst_s_ready", 64'(bus.s_ready), 64'd1);

        // Full frame 0x0..0x1F
        bus.m_ready = 1'b1;
        clr_ew();
        for (int i = 0; i < 31; i++) begin
            send_word(word_t'(i), 1'b0);
            ew[i] = word_t'(i);
        end
        chk("full_not_yet_valid", 64'(bus.m_valid), 64'd0);
        send_word(32'h1F, 1'b0);
        ew[31] = 32'h1F;
        chk("full_m_valid", 64'(bus.m_valid), 64'd1);
        chk("full_m_count", 64'(bus.m_count), 64'd32);
        chk("full_top_word", 64'(bus.m_data[1023:992]), 64'h0);
        chk("full_low_word", 64'(bus.m_data[31:0]), 64'h1F);
        chk_vec("full_m_data", bus.m_data, build());
        step();
        chk("full_drained", 64'(bus.m_valid), 64'd0);

        // Short frame with idle gaps (garbage data while s_valid low)
        clr_ew();
        send_word(32'hAAAA0001, 1'b0);
        step();
        send_word(32'hAAAA0002, 1'b0);
        step();
        step();
        chk("short_gap_no_valid", 64'(bus.m_valid), 64'd0);
        send_word(32'hAAAA0003, 1'b1);
        ew[0] = 32'hAAAA0001; ew[1] = 32'hAAAA0002; ew[2] = 32'hAAAA0003;
        chk("short_m_valid", 64'(bus.m_valid), 64'd1);
        chk("short_m_count", 64'(bus.m_count), 64'd3);
        chk("short_top3_hi", 64'(bus.m_data[1023:992]), 64'hAAAA0001);
        chk("short_top3_mid", 64'(bus.m_data[991:960]), 64'hAAAA0002);
        chk("short_top3_lo", 64'(bus.m_data[959:928]), 64'hAAAA0003);
        chk("short_pad", 64'(bus.m_data[927:0] == '0), 64'd1);
        chk_vec("short_m_data", bus.m_data, build());
        step();
        chk("short_drained", 64'(bus.m_valid), 64'd0);

        // s_last on slot 0
        send_word(32'hDEADBEEF, 1'b1);
        clr_ew();
        ew[0] = 32'hDEADBEEF;
        chk("one_m_count", 64'(bus.m_count), 64'd1);
        chk_vec("one_m_data", bus.m_data, build());
        step();
        chk("one_drained", 64'(bus.m_valid), 64'd0);

        // Backpressure: two full frames with m_ready low
        bus.m_ready = 1'b0;
        clr_ew();
        for (int i = 0; i < NUM_WORDS; i++) ew[i] = 32'h200 + word_t'(i);
        vec_a = build();
        for (int i = 0; i < NUM_WORDS; i++) ew[i] = 32'h300 + word_t'(i);
        vec_b = build();
        for (int i = 0; i < NUM_WORDS; i++) send_word(32'h200 + word_t'(i), 1'b0);
        chk("bp_a_valid", 64'(bus.m_valid), 64'd1);
        chk("bp_s_ready_mid", 64'(bus.s_ready), 64'd1);
        for (int i = 0; i < NUM_WORDS; i++) send_word(32'h300 + word_t'(i), 1'b0);
        chk("bp_s_ready_low", 64'(bus.s_ready), 64'd0);
        chk_vec("bp_a_data", bus.m_data, vec_a);
        step();
        step();
        chk("bp_s_ready_still_low", 64'(bus.s_ready), 64'd0);
        chk_vec("bp_a_held", bus.m_data, vec_a);
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk("bp_b_valid", 64'(bus.m_valid), 64'd1);
        chk("bp_s_ready_back", 64'(bus.s_ready), 64'd1);
        chk("bp_b_count", 64'(bus.m_count), 64'd32);
        chk_vec("bp_b_data", bus.m_data, vec_b);
        step();
        chk_vec("bp_b_held", bus.m_data, vec_b);
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk("bp_drained", 64'(bus.m_valid), 64'd0);

        // Simultaneous handshake of A and completion of B (s_last on slot 31)
        for (int i = 0; i < NUM_WORDS; i++) ew[i] = 32'h400 + word_t'(i);
        vec_a = build();
        for (int i = 0; i < NUM_WORDS; i++) ew[i] = 32'h500 + word_t'(i);
        vec_b = build();
        for (int i = 0; i < NUM_WORDS; i++) send_word(32'h400 + word_t'(i), 1'b0);
        for (int i = 0; i < NUM_WORDS - 1; i++) send_word(32'h500 + word_t'(i), 1'b0);
        chk_vec("sim_a_data", bus.m_data, vec_a);
        bus.m_ready = 1'b1;
        send_word(32'h51F, 1'b1);
        chk("sim_m_valid", 64'(bus.m_valid), 64'd1);
        chk("sim_s_ready", 64'(bus.s_ready), 64'd1);
        chk("sim_b_count", 64'(bus.m_count), 64'd32);
        chk_vec("sim_b_data", bus.m_data, vec_b);
        step();
        bus.m_ready = 1'b0;
        chk("sim_drained", 64'(bus.m_valid), 64'd0);

        // Reset mid-frame
        for (int i = 0; i < 10; i++) send_word(32'h600 + word_t'(i), 1'b0);
        rst_n = 1'b0;
        step();
        chk("mid_rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("mid_rst_m_valid", 64'(bus.m_valid), 64'd0);
        rst_n = 1'b1;
        clr_ew();
        for (int i = 0; i < NUM_WORDS; i++) begin
            ew[i] = 32'h100 + word_t'(i);
            send_word(32'h100 + word_t'(i), 1'b0);
        end
        vec_a = build();
        chk("mid_m_valid", 64'(bus.m_valid), 64'd1);
        chk("mid_m_count", 64'(bus.m_count), 64'd32);
        chk_vec("mid_m_data", bus.m_data, vec_a);

        // Stability under 20 cycles of backpressure
        for (int c = 0; c < 20; c++) begin
            step();
            chk("stab_m_valid", 64'(bus.m_valid), 64'd1);
            chk("stab_m_count", 64'(bus.m_count), 64'd32);
            chk_vec("stab_m_data", bus.m_data, vec_a);
        end
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk("stab_drained", 64'(bus.m_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vec_packer32.md
# vec_packer32

Serial-to-parallel collector that sits on the producer side of the max-reduction datapath. It accepts 32-bit words one per handshake and assembles them into the 1024-bit packed vector consumed by the reduction stage. It pads short frames with a neutral value and presents each complete vector through a valid/ready output register. A fill buffer plus an output register give full throughput, with one word per cycle sustained.

## Interface
- WORD_W, 32, bits per word
- NUM_WORDS, 32, words per packed vector
- PAD_VALUE, 0, fill value for unreceived slots (0 is the unsigned minimum, so downstream max is unaffected)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- s_valid  in  1  input word valid
- s_ready  out  1  block can accept a word
- s_data  in  WORD_W  input word
- s_last  in  1  word closes the frame early (qualified by s_valid & s_ready)
- m_valid  out  1  packed vector valid
- m_ready  in  1  downstream accepts vector
- m_data  out  WORD_W*NUM_WORDS  packed vector; word k occupies bits [VEC_W-1-k*WORD_W -: WORD_W] (word 0 in MSBs)
- m_count  out  $clog2(NUM_WORDS)+1  number of real (non-pad) words in m_data, 1..NUM_WORDS

## Operation
- Fill buffer: NUM_WORDS slots, write pointer wr_idx (0..NUM_WORDS-1), flag fill_full.
- Output register: m_data, m_count, m_valid.
- Word accept: s_valid & s_ready writes s_data into slot wr_idx, and wr_idx increments.
- Frame completes on an accepted word when wr_idx == NUM_WORDS-1 or s_last == 1.
- On completion, the frame's count is wr_idx+1.
- Transfer to the output register occurs when it is free (m_valid == 0, or m_valid & m_ready this cycle):
  - the completed frame loads into the output register on the same edge; the completing word is included;
  - m_valid = 1 and m_count = count;
  - the fill buffer resets to all PAD_VALUE and wr_idx = 0.
- If the output register is not free at completion, the frame stays in the fill buffer:
  - fill_full = 1 and s_ready = 0;
  - the transfer fires on the first cycle m_ready is seen high, then fill_full clears.
- s_ready = rst_n & ~fill_full.
- An output handshake with no pending frame clears m_valid.
- s_last on slot NUM_WORDS-1 is identical to a natural full frame.
- s_last on slot 0 gives m_count = 1 and slots 1..31 = PAD_VALUE.
- Inputs with s_valid low are ignored. s_data and s_last are don't-care when not accepted.
- Outputs are held stable while m_valid & ~m_ready (AXI-stream rule).
- States: FILLING (fill_full = 0) and HOLD (fill_full = 1).
  - FILLING -> HOLD: completion while the output register is busy.
  - HOLD -> FILLING: m_ready.

## Timing
- Reset (rst_n low at an edge) sets:
  - m_valid = 0, m_count = 0, m_data = all PAD_VALUE;
  - wr_idx = 0, fill_full = 0, fill buffer = all PAD_VALUE.
- s_ready is 0 while rst_n is low and 1 from the first cycle after.
- Reset mid-frame discards partial words and any held or output frame without emitting them.
- Latency: accepting the completing word in cycle t gives m_valid = 1 in cycle t+1.
- Throughput: back-to-back frames at 1 word/cycle with no bubbles, provided each vector is taken (m_ready) by the cycle its successor completes.
- Simultaneous output handshake and completion: m_valid stays 1 and new data appears in the next cycle.
- Maximum stall: s_ready drops for the cycle after completion into a busy output, and remains low until m_ready.

## Structure
- Package vec_pack_pkg holds:
  - WORD_W and NUM_WORDS defaults;
  - localparams VEC_W = WORD_W*NUM_WORDS, CNT_W = $clog2(NUM_WORDS)+1;
  - typedefs word_t (logic [WORD_W-1:0]), vec_t (logic [VEC_W-1:0]), cnt_t.
- A helper function in the package returns the bit offset for slot k.
- Single module, no sub-module. The fill buffer and output register are each small enough to stay inline.

## Test plan
- Full frame: words 0x0..0x1F, one per cycle, m_ready = 1 -> m_valid 1 cycle after word 31; m_data[1023:992] = 0x0, m_data[31:0] = 0x1F; m_count = 32.
- Short frame: 0xAAAA0001, 0xAAAA0002, 0xAAAA0003 with s_last on the third word -> m_count = 3; bits [1023:928] hold the three words; the remaining 29 slots = 0.
- Backpressure: m_ready = 0, send two full frames -> s_ready falls after word 63 completes. Raise m_ready for 1 cycle -> second frame moves to the output and s_ready returns to 1 the next cycle. Both vectors are intact and in order.
- Simultaneous events: complete frame B in the same cycle frame A is handshaken -> m_valid stays high and m_data = B the next cycle, with no dropped or duplicated vector.
- Reset mid-frame: 10 words in, then rst_n = 0 for 1 cycle, then 32 words 0x100..0x11F -> the single output vector contains only 0x100..0x11F and m_count = 32.
- Stability: hold m_ready = 0 for 20 cycles with m_valid = 1 -> m_data and m_count are unchanged every cycle.
